cpx_divide: RTL and testbench

Pipelined-handshake complex divider computing (xi + j·xq) / (yi + j·yq) as fixed-point I/Q with `frac_bits` fractional bits. It is the inverse companion to `cpx_multiply` in the CAF datapath, used to normalise or de-rotate a complex sample by a complex reference. The block is multi-cycle and non-pipelined: it runs one division at a time through a valid/ready front end, a bit-serial restoring divide core, and a valid/ready back end.

---
 rtl/cpx_pkg.sv | 43 ++++
 rtl/udiv_serial.sv | 63 ++++++
 rtl/cpx_divide.sv | 184 ++++++++++++++++++
 tb/tb_cpx_divide.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cpx_pkg.sv
// cpx_pkg: shared types and helpers for the complex divider.
//   - state_t       : FSM states of cpx_divide
//   - IN_BITS/FRAC_BITS/OUT_BITS : default widths
//   - iter_of()     : number of quotient bits produced by the serial divider
//   - sat_wrap()    : optional clamp of a signed value to an out_w-bit range
package cpx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MULT = 3'd1,
        ST_SUM  = 3'd2,
        ST_DIV  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int IN_BITS   = 12;
    localparam int FRAC_BITS = 12;
    localparam int OUT_BITS  = 16;

    // Quotient bits: full numerator magnitude width plus the fractional shift.
    function automatic int iter_of(input int in_w, input int frac_w);
        return 2 * in_w + 1 + frac_w;
    endfunction

    // With sat_en set, clamp val into the signed out_w-bit range; otherwise
    // pass it through so the caller's truncation performs a two's-complement wrap.
    function automatic logic signed [63:0] sat_wrap(input logic signed [63:0] val,
                                                    input int out_w,
                                                    input logic sat_en);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 1));
        if (sat_en && (val > max_v)) begin
            return max_v;
        end else if (sat_en && (val < min_v)) begin
            return min_v;
        end else begin
            return val;
        end
    endfunction

endpackage

// File: rtl/udiv_serial.sv
// udiv_serial: one-bit-per-cycle unsigned restoring divider datapath.
// The caller owns the iteration count; this block only performs steps.
//   clk, rst_n  : clock, async active-low reset
//   i_load      : load i_dividend and clear the remainder
//   i_step      : perform one restoring step
//   i_dividend  : DW-bit unsigned dividend (MSB consumed first)
//   i_divisor   : VW-bit unsigned divisor, held stable while stepping
//   o_quotient  : quotient after DW steps
module udiv_serial #(
    parameter int DW = 37,
    parameter int VW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [DW-1:0] i_dividend,
    input  logic [VW-1:0] i_divisor,
    output logic [DW-1:0] o_quotient
);

    // Dividend bits shift out of the top while quotient bits shift in below.
    logic [VW-1:0] r_rem;
    logic [DW-1:0] r_dq;
    logic [VW:0]   w_trial;
    logic [VW-1:0] w_rem_nxt;
    logic          w_qbit;

    // Trial subtraction for the next restoring step.
    always_comb begin
        w_trial   = {r_rem, r_dq[DW-1]};
        w_qbit    = 1'b0;
        w_rem_nxt = w_trial[VW-1:0];
        if (w_trial >= {1'b0, i_divisor}) begin
            w_qbit    = 1'b1;
            // Difference is below the divisor, so the low VW bits are exact.
            w_rem_nxt = w_trial[VW-1:0] - i_divisor;
        end else begin
            w_qbit    = 1'b0;
            w_rem_nxt = w_trial[VW-1:0];
        end
    end

    // Remainder and dividend/quotient shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_dq  <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_dq  <= i_dividend;
        end else if (i_step) begin
            r_rem <= w_rem_nxt;
            r_dq  <= {r_dq[DW-2:0], w_qbit};
        end else begin
            r_rem <= r_rem;
            r_dq  <= r_dq;
        end
    end

    assign o_quotient = r_dq;

endmodule

// File: rtl/cpx_divide.sv
// cpx_divide: multi-cycle complex divider (xi + j*xq) / (yi + j*yq).
// Result i/q are signed with frac_bits fractional bits, out_bits wide.
// Build option: define CPX_DIVIDE_SAT_EN to clamp out-of-range results;
// otherwise results wrap (low out_bits bits of the signed quotient).
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : operand handshake
//   xi, xq, yi, yq        : signed numerator / denominator components
//   out_valid / out_ready : result handshake
//   i, q                  : signed quotient components
//   div_zero              : denominator was 0+0j for this result
module cpx_divide
    import cpx_pkg::*;
#(
    parameter int in_bits   = IN_BITS,
    parameter int frac_bits = FRAC_BITS,
    parameter int out_bits  = OUT_BITS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [in_bits-1:0]  xi,
    input  logic signed [in_bits-1:0]  xq,
    input  logic signed [in_bits-1:0]  yi,
    input  logic signed [in_bits-1:0]  yq,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [out_bits-1:0] i,
    output logic signed [out_bits-1:0] q,
    output logic                       div_zero
);

    localparam int ITER = iter_of(in_bits, frac_bits);
    localparam int PW   = 2 * in_bits;
    localparam int NW   = 2 * in_bits + 1;
    localparam int CW   = $clog2(ITER + 1);

`ifdef CPX_DIVIDE_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    state_t                       r_state;
    logic signed [in_bits-1:0]    r_xi, r_xq, r_yi, r_yq;
    logic signed [PW-1:0]         r_p_ii, r_p_qq, r_p_qi, r_p_iq;
    logic        [PW-1:0]         r_sq_i, r_sq_q;
    logic        [PW-1:0]         r_den;
    logic                         r_den_zero;
    logic                         r_sign_i, r_sign_q;
    logic        [CW-1:0]         r_cnt;
    logic signed [out_bits-1:0]   r_i, r_q;
    logic                         r_dz;

    logic [NW-1:0]      w_num_i, w_num_q, w_mag_i, w_mag_q;
    logic [PW-1:0]      w_den;
    logic [ITER-1:0]    w_quo_i, w_quo_q;
    logic signed [ITER:0] w_qs_i, w_qs_q;
    logic               w_load, w_step;

    // Cross sums on sign-extended products, magnitudes for the unsigned core.
    assign w_num_i = {r_p_ii[PW-1], r_p_ii} + {r_p_qq[PW-1], r_p_qq};
    assign w_num_q = {r_p_qi[PW-1], r_p_qi} - {r_p_iq[PW-1], r_p_iq};
    assign w_den   = r_sq_i + r_sq_q;
    assign w_mag_i = w_num_i[NW-1] ? (NW'(0) - w_num_i) : w_num_i;
    assign w_mag_q = w_num_q[NW-1] ? (NW'(0) - w_num_q) : w_num_q;

    assign w_load = (r_state == ST_SUM);
    assign w_step = (r_state == ST_DIV) && !r_den_zero && (r_cnt != CW'(ITER));

    assign w_qs_i = r_sign_i ? -$signed({1'b0, w_quo_i}) : $signed({1'b0, w_quo_i});
    assign w_qs_q = r_sign_q ? -$signed({1'b0, w_quo_q}) : $signed({1'b0, w_quo_q});

    udiv_serial #(.DW(ITER), .VW(PW)) u_div_i (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_dividend ({w_mag_i, {frac_bits{1'b0}}}),
        .i_divisor  (r_den),
        .o_quotient (w_quo_i)
    );

    udiv_serial #(.DW(ITER), .VW(PW)) u_div_q (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_dividend ({w_mag_q, {frac_bits{1'b0}}}),
        .i_divisor  (r_den),
        .o_quotient (w_quo_q)
    );

    // Control FSM with operand, product, sum and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_xi       <= '0;
            r_xq       <= '0;
            r_yi       <= '0;
            r_yq       <= '0;
            r_p_ii     <= '0;
            r_p_qq     <= '0;
            r_p_qi     <= '0;
            r_p_iq     <= '0;
            r_sq_i     <= '0;
            r_sq_q     <= '0;
            r_den      <= '0;
            r_den_zero <= 1'b0;
            r_sign_i   <= 1'b0;
            r_sign_q   <= 1'b0;
            r_cnt      <= '0;
            r_i        <= '0;
            r_q        <= '0;
            r_dz       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_xi    <= xi;
                        r_xq    <= xq;
                        r_yi    <= yi;
                        r_yq    <= yq;
                        r_state <= ST_MULT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MULT: begin
                    r_p_ii  <= r_xi * r_yi;
                    r_p_qq  <= r_xq * r_yq;
                    r_p_qi  <= r_xq * r_yi;
                    r_p_iq  <= r_xi * r_yq;
                    r_sq_i  <= r_yi * r_yi;
                    r_sq_q  <= r_yq * r_yq;
                    r_state <= ST_SUM;
                end
                ST_SUM: begin
                    r_den      <= w_den;
                    r_den_zero <= (w_den == PW'(0));
                    r_sign_i   <= w_num_i[NW-1];
                    r_sign_q   <= w_num_q[NW-1];
                    r_cnt      <= '0;
                    r_state    <= ST_DIV;
                end
                ST_DIV: begin
                    // Zero denominator is resolved on the first DIV cycle so the
                    // shortcut result appears three edges after acceptance.
                    if (r_den_zero) begin
                        r_i     <= '0;
                        r_q     <= '0;
                        r_dz    <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_cnt == CW'(ITER)) begin
                        r_i     <= out_bits'(sat_wrap(64'(w_qs_i), out_bits, SAT_EN));
                        r_q     <= out_bits'(sat_wrap(64'(w_qs_q), out_bits, SAT_EN));
                        r_dz    <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                        r_state <= ST_DIV;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign i         = r_i;
    assign q         = r_q;
    assign div_zero  = r_dz;

endmodule

// File: tb/tb_cpx_divide.sv
module tb_cpx_divide;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [11:0] xi, xq, yi, yq;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] dut_i, dut_q;
    logic               div_zero;

    int n_tests;
    int n_fail;

    cpx_divide dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .xi        (xi),
        .xq        (xq),
        .yi        (yi),
        .yq        (yq),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .i         (dut_i),
        .q         (dut_q),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int xi, xq, yi, yq;
        int ei, eq, edz, elat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present one operand set, measure edges from acceptance to out_valid.
    task automatic run_op(input int a, input int b, input int c, input int d, output int lat);
        @(negedge clk);
        check("in_ready_before_op", in_ready, 1);
        xi = 12'(a); xq = 12'(b); yi = 12'(c); yq = 12'(d);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("in_ready_after_hs", in_ready, 1);
        check("out_valid_after_hs", out_valid, 0);
    endtask

    initial begin
        int lat;
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{30, 0, 10, 0, 12288, 0, 0, 40};
        vecs[1] = '{3, 4, 1, 2, 9011, -1638, 0, 40};
        vecs[2] = '{5, -7, 0, 0, 0, 0, 1, 3};
        vecs[3] = '{1, 1, 0, 1, 4096, -4096, 0, 40};
        vecs[4] = '{7, 0, -3, 0, -9557, 0, 0, 40};
`ifdef CPX_DIVIDE_SAT_EN
        vecs[5] = '{100, 0, 10, 0, 32767, 0, 0, 40};
        vecs[6] = '{-100, 0, 10, 0, -32768, 0, 0, 40};
`else
        vecs[5] = '{100, 0, 10, 0, -24576, 0, 0, 40};
        vecs[6] = '{-100, 0, 10, 0, 24576, 0, 0, 40};
`endif
        vecs[7] = '{0, 0, 5, 5, 0, 0, 0, 40};
        vecs[8] = '{2047, 2047, -2048, 0, -4094, -4094, 0, 40};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        xi = '0; xq = '0; yi = '0; yq = '0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_i", dut_i, 0);
        check("rst_q", dut_q, 0);
        check("rst_div_zero", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors.
        for (int k = 0; k < 9; k++) begin
            run_op(vecs[k].xi, vecs[k].xq, vecs[k].yi, vecs[k].yq, lat);
            check($sformatf("v%0d_latency", k), lat, vecs[k].elat);
            check($sformatf("v%0d_i", k), dut_i, vecs[k].ei);
            check($sformatf("v%0d_q", k), dut_q, vecs[k].eq);
            check($sformatf("v%0d_div_zero", k), div_zero, vecs[k].edz);
            handshake();
        end

        // Backpressure: result held, new operands ignored.
        run_op(3, 4, 1, 2, lat);
        check("bp_latency", lat, 40);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            xi = 12'sd30; xq = 12'sd0; yi = 12'sd10; yq = 12'sd0;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp_i_stable", dut_i, 9011);
            check("bp_q_stable", dut_q, -1638);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        handshake();
        repeat (3) @(posedge clk);
        #1;
        check("bp_ignored_idle", in_ready, 1);
        check("bp_ignored_no_result", out_valid, 0);

        // Reset in the middle of DIV.
        @(negedge clk);
        xi = 12'sd1; xq = 12'sd1; yi = 12'sd0; yq = 12'sd1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_i", dut_i, 0);
        check("midrst_q", dut_q, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(30, 0, 10, 0, lat);
        check("postrst_latency", lat, 40);
        check("postrst_i", dut_i, 12288);
        check("postrst_q", dut_q, 0);
        handshake();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
